// File: rtl/eqn_streak_detect_if.sv
// Operand/status bundle for eqn_streak_detect: sample strobe and operands in,
// registered compare flags, streak indicator and counters out.
interface eqn_streak_detect_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             ledpin;
    logic [CNT_W-1:0] streak_cnt;
    logic [15:0]      match_total;

    modport master (
        output in_valid, a, b,
        input  out_valid, eq, gt, lt, ledpin, streak_cnt, match_total
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, eq, gt, lt, ledpin, streak_cnt, match_total
    );
endinterface

// File: rtl/eqn_streak_detect.sv
// Registered equality/magnitude compare with match-streak LED lock and hold-off.
// Define SIGNED_CMP_EN to make gt/lt compare two's-complement operands.
module eqn_streak_detect #(
    parameter int WIDTH    = 8,
    parameter int STREAK   = 4,
    parameter int HOLD_CYC = 16,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    eqn_streak_detect_if.slave   bus
);
    localparam int TMR_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STREAK_C  = CNT_W'(STREAK);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LOCK  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [CNT_W-1:0] streak_r, streak_s;
    logic [15:0]      total_r, total_s;
    logic [WIDTH-1:0] a_s, b_s;
    logic             match_s, miss_s, hit_s, gt_s, lt_s;
    logic             eq_r, gt_r, lt_r, ov_r, led_r;

    // Operand compare for the sample presented this cycle
    always_comb begin
        a_s     = bus.a;
        b_s     = bus.b;
        match_s = bus.in_valid & (a_s == b_s);
        miss_s  = bus.in_valid & (a_s != b_s);
`ifdef SIGNED_CMP_EN
        gt_s    = ($signed(a_s) > $signed(b_s));
        lt_s    = ($signed(a_s) < $signed(b_s));
`else
        gt_s    = (a_s > b_s);
        lt_s    = (a_s < b_s);
`endif
    end

    // Saturating streak and total counters; hit_s flags the edge a streak completes
    always_comb begin
        streak_s = streak_r;
        total_s  = total_r;
        if (match_s) begin
            if (streak_r != CNT_MAX) begin
                streak_s = streak_r + CNT_W'(1);
            end else begin
                streak_s = streak_r;
            end
            if (total_r != 16'hFFFF) begin
                total_s = total_r + 16'd1;
            end else begin
                total_s = total_r;
            end
        end else if (miss_s) begin
            streak_s = {CNT_W{1'b0}};
        end else begin
            streak_s = streak_r;
        end
        hit_s = match_s & (streak_s >= STREAK_C);
    end

    // Lock/hold next-state; a relock always beats timer expiry
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        case (state_r)
            ST_IDLE, ST_COUNT: begin
                if (hit_s) begin
                    state_s = ST_LOCK;
                end else if (match_s) begin
                    state_s = ST_COUNT;
                end else if (miss_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOCK: begin
                if (miss_s) begin
                    state_s = ST_HOLD;
                    timer_s = HOLD_LOAD;
                end else begin
                    state_s = ST_LOCK;
                end
            end
            ST_HOLD: begin
                if (hit_s) begin
                    state_s = ST_LOCK;
                    timer_s = {TMR_W{1'b0}};
                end else if (timer_r == {TMR_W{1'b0}}) begin
                    state_s = (streak_s != {CNT_W{1'b0}}) ? ST_COUNT : ST_IDLE;
                end else begin
                    timer_s = timer_r - TMR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = {TMR_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            timer_r  <= {TMR_W{1'b0}};
            streak_r <= {CNT_W{1'b0}};
            total_r  <= 16'd0;
            eq_r     <= 1'b0;
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
            ov_r     <= 1'b0;
            led_r    <= 1'b0;
        end else if (clear) begin
            state_r  <= ST_IDLE;
            timer_r  <= {TMR_W{1'b0}};
            streak_r <= {CNT_W{1'b0}};
            total_r  <= 16'd0;
            eq_r     <= 1'b0;
            gt_r     <= 1'b0;
            lt_r     <= 1'b0;
            ov_r     <= 1'b0;
            led_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            streak_r <= streak_s;
            total_r  <= total_s;
            ov_r     <= bus.in_valid;
            led_r    <= (state_s == ST_LOCK) || (state_s == ST_HOLD);
            if (bus.in_valid) begin
                eq_r <= match_s;
                gt_r <= gt_s;
                lt_r <= lt_s;
            end
        end
    end

    assign bus.out_valid   = ov_r;
    assign bus.eq          = eq_r;
    assign bus.gt          = gt_r;
    assign bus.lt          = lt_r;
    assign bus.ledpin      = led_r;
    assign bus.streak_cnt  = streak_r;
    assign bus.match_total = total_r;
endmodule

// File: tb/tb_eqn_streak_detect.sv
// Randomized and directed bench for eqn_streak_detect against a behavioural model
// (ledpin = streak at threshold, or a lock broken fewer than HOLD_CYC edges ago).
module tb_eqn_streak_detect;
    localparam int WIDTH    = 8;
    localparam int STREAK   = 3;
    localparam int HOLD_CYC = 4;
    localparam int CNT_W    = 8;

    logic clk;
    logic rst_n;
    logic clear;

    eqn_streak_detect_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    eqn_streak_detect #(
        .WIDTH(WIDTH), .STREAK(STREAK), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // reference model state
    int m_ov, m_eq, m_gt, m_lt, m_streak, m_total;
    int m_edge, m_break, m_seen;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sx(input logic [7:0] x);
`ifdef SIGNED_CMP_EN
        return x[7] ? int'(x) - 256 : int'(x);
`else
        return int'(x);
`endif
    endfunction

    task automatic model_reset();
        m_ov = 0; m_eq = 0; m_gt = 0; m_lt = 0;
        m_streak = 0; m_total = 0; m_seen = 0; m_break = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic clr);
        if (clr) begin
            model_reset();
        end else begin
            m_edge++;
            m_ov = int'(v);
            if (v) begin
                m_eq = (av == bv) ? 1 : 0;
                m_gt = (sx(av) > sx(bv)) ? 1 : 0;
                m_lt = (sx(av) < sx(bv)) ? 1 : 0;
                if (av == bv) begin
                    m_streak = (m_streak < 255) ? m_streak + 1 : 255;
                    m_total  = (m_total < 65535) ? m_total + 1 : 65535;
                end else begin
                    if (m_streak >= STREAK) begin
                        m_seen  = 1;
                        m_break = m_edge;
                    end
                    m_streak = 0;
                end
            end
        end
    endtask

    function automatic int model_led();
        if (m_streak >= STREAK) return 1;
        if (m_seen != 0 && (m_edge - m_break) < HOLD_CYC) return 1;
        return 0;
    endfunction

    task automatic compare_all();
        chk("out_valid",   int'(bus.out_valid),   m_ov);
        chk("eq",          int'(bus.eq),          m_eq);
        chk("gt",          int'(bus.gt),          m_gt);
        chk("lt",          int'(bus.lt),          m_lt);
        chk("ledpin",      int'(bus.ledpin),      model_led());
        chk("streak_cnt",  int'(bus.streak_cnt),  m_streak);
        chk("match_total", int'(bus.match_total), m_total);
    endtask

    task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic clr);
        @(negedge clk);
        bus.in_valid = v; bus.a = av; bus.b = bv; clear = clr;
        @(posedge clk);
        model_edge(v, av, bv, clr);
        #1;
        compare_all();
    endtask

    initial begin
        logic       v;
        logic [7:0] av, bv;
        logic       clr;
        n_cmp = 0; n_bad = 0; m_edge = 0;
        model_reset();
        rst_n = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // lock: streak 1,2,3 then ledpin
        step(1'b1, 8'h5A, 8'h5A, 1'b0);
        chk("lock_s1", int'(bus.streak_cnt), 1);
        step(1'b1, 8'h5A, 8'h5A, 1'b0);
        chk("lock_led_early", int'(bus.ledpin), 0);
        step(1'b1, 8'h5A, 8'h5A, 1'b0);
        chk("lock_led", int'(bus.ledpin), 1);
        chk("lock_total", int'(bus.match_total), 3);

        // break lock, ledpin held exactly HOLD_CYC cycles
        step(1'b1, 8'h5A, 8'h5B, 1'b0);
        chk("hold_lt", int'(bus.lt), 1);
        for (int i = 0; i < HOLD_CYC; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
        chk("hold_off", int'(bus.ledpin), 0);
        chk("hold_streak", int'(bus.streak_cnt), 0);

        // relock inside the hold window
        for (int i = 0; i < STREAK; i++) step(1'b1, 8'h33, 8'h33, 1'b0);
        step(1'b1, 8'h10, 8'h20, 1'b0);
        for (int i = 0; i < STREAK; i++) begin
            step(1'b1, 8'h44, 8'h44, 1'b0);
            chk("relock_led", int'(bus.ledpin), 1);
        end
        for (int i = 0; i < HOLD_CYC + 2; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
        chk("relock_stay", int'(bus.ledpin), 1);

        // async reset while locked
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led",   int'(bus.ledpin), 0);
        chk("arst_streak", int'(bus.streak_cnt), 0);
        chk("arst_total", int'(bus.match_total), 0);
        chk("arst_ov",    int'(bus.out_valid), 0);
        model_reset();
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b1;

        // clear wins over a matching sample
        step(1'b1, 8'h77, 8'h77, 1'b1);
        chk("clr_streak", int'(bus.streak_cnt), 0);
        step(1'b1, 8'h77, 8'h77, 1'b0);
        step(1'b1, 8'h77, 8'h77, 1'b1);
        chk("clr_total", int'(bus.match_total), 0);

        // gaps preserve the streak
        step(1'b1, 8'h01, 8'h01, 1'b0);
        step(1'b0, 8'h01, 8'h02, 1'b0);
        step(1'b1, 8'h01, 8'h01, 1'b0);
        chk("gap_streak", int'(bus.streak_cnt), 2);

        // saturation
        for (int i = 0; i < 300; i++) step(1'b1, 8'hC3, 8'hC3, 1'b0);
        chk("sat_streak", int'(bus.streak_cnt), 255);

        // sign handling
        step(1'b1, 8'h80, 8'h01, 1'b0);
`ifdef SIGNED_CMP_EN
        chk("signed_lt", int'(bus.lt), 1);
`else
        chk("unsigned_gt", int'(bus.gt), 1);
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 9) < 7);
            av  = 8'($urandom);
            bv  = ($urandom_range(0, 3) != 0) ? av : 8'($urandom);
            clr = ($urandom_range(0, 99) == 0);
            step(v, av, bv, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
